// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction prefetch stage.
// Provides address/word widths, fetch FSM state codes, the FIFO entry
// layout {pc, word} and a saturating 16-bit increment helper.
package fetch_pkg;

  localparam int ADDR_W = 16;
  localparam int WORD_W = 16;

  // Fetch FSM states. Kept as plain 2-bit constants so the debug port
  // carries the raw code.
  localparam logic [1:0] FS_RUN    = 2'd0;
  localparam logic [1:0] FS_HOLD   = 2'd1;
  localparam logic [1:0] FS_HALTED = 2'd2;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [WORD_W-1:0] word;
  } fetch_ent_t;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

endpackage

// File: rtl/prefetch_fifo.sv
// Synchronous FIFO of {pc, word} entries with flush and occupancy count.
// Latency: a word pushed in cycle c is visible at the head in cycle c+1.
// Backpressure: the caller must not push when full; pop is ignored when empty.
// Ports: clk_i/rst_i (sync, active-high), flush_i empties the FIFO and wins
//        over push/pop, push_i/push_dat_i write, pop_i removes the head,
//        count_o occupancy, head_vld_o/head_dat_o registered head entry.
module prefetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             push_i,
  input  fetch_ent_t       push_dat_i,
  input  logic             pop_i,
  output logic [CNT_W-1:0] count_o,
  output logic             head_vld_o,
  output fetch_ent_t       head_dat_o
);

  fetch_ent_t       mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_pop;

  assign do_pop = pop_i && (count_q != '0);

  // Storage is cleared on reset so the head reads as zero until the
  // first write lands.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_ptr_q] <= push_dat_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({push_i, do_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign count_o    = count_q;
  assign head_vld_o = (count_q != '0);
  assign head_dat_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/insn_prefetch.sv
// Instruction prefetch: issues sequential ROM reads ahead of the core and queues {pc, word}.
// Latency: ROM address registered, data one cycle later, FIFO head one cycle after that (3 cycles).
// Backpressure: reads issue only while FIFO occupancy plus the in-flight read leaves room.
// Ports: clock/reset (sync, active-high); address_rom/q_rom ROM read port;
//        insn_valid/insn_word/insn_pc/insn_ready head handshake to the core;
//        redirect/redirect_pc flush and restart; halt stops issuing (sticky);
//        fetch_state debug; stat_words/stat_flushes counters.
// Build option: define PREFETCH_STATS_EN to build the saturating counters;
//        otherwise both stat outputs read 16'h0000.
module insn_prefetch
  import fetch_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = 16'h0000
) (
  input  logic              clock,
  input  logic              reset,
  output logic [ADDR_W-1:0] address_rom,
  input  logic [WORD_W-1:0] q_rom,
  output logic              insn_valid,
  output logic [WORD_W-1:0] insn_word,
  output logic [ADDR_W-1:0] insn_pc,
  input  logic              insn_ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt,
  output logic [1:0]        fetch_state,
  output logic [15:0]       stat_words,
  output logic [15:0]       stat_flushes
);

  localparam int               CNT_W   = $clog2(DEPTH) + 1;
  localparam logic [CNT_W:0]   DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              inflight_q, inflight_d;
  logic [1:0]        state_q, state_d;

  logic [CNT_W-1:0]  fifo_count;
  logic              credit;
  logic              issue;
  logic              push;
  fetch_ent_t        push_dat;
  fetch_ent_t        head_dat;

  // The in-flight read already owns a slot. A pop in the same cycle is not
  // counted, so the FIFO can never be asked to take more than DEPTH words.
  assign credit = ({1'b0, fifo_count} + {{CNT_W{1'b0}}, inflight_q}) < DEPTH_C;
  assign issue  = (state_q == FS_RUN) && credit && !halt;

  // A redirect kills the word returning this cycle.
  assign push     = inflight_q && !redirect;
  assign push_dat = '{pc: pc_q, word: q_rom};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    pc_d       = pc_q;
    inflight_d = 1'b0;
    state_d    = state_q;

    if (issue) begin
      pc_d       = fetch_pc_q;
      fetch_pc_d = fetch_pc_q + ADDR_W'(1);
      inflight_d = 1'b1;
    end

    case (state_q)
      FS_RUN: begin
        if (halt)         state_d = FS_HALTED;
        else if (!credit) state_d = FS_HOLD;
      end
      FS_HOLD: begin
        if (halt)        state_d = FS_HALTED;
        else if (credit) state_d = FS_RUN;
      end
      FS_HALTED: state_d = FS_HALTED;
      default:   state_d = FS_RUN;
    endcase

    // Redirect overrides everything except reset.
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      state_d    = FS_RUN;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      fetch_pc_q <= RESET_PC;
      pc_q       <= '0;
      inflight_q <= 1'b0;
      state_q    <= FS_RUN;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      state_q    <= state_d;
    end
  end

  prefetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i      (clock),
    .rst_i      (reset),
    .flush_i    (redirect),
    .push_i     (push),
    .push_dat_i (push_dat),
    .pop_i      (insn_ready),
    .count_o    (fifo_count),
    .head_vld_o (insn_valid),
    .head_dat_o (head_dat)
  );

  assign address_rom = fetch_pc_q;
  assign insn_word   = head_dat.word;
  assign insn_pc     = head_dat.pc;
  assign fetch_state = state_q;

`ifdef PREFETCH_STATS_EN
  logic [15:0] stat_words_q;
  logic [15:0] stat_flushes_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      stat_words_q   <= '0;
      stat_flushes_q <= '0;
    end else begin
      if (push) begin
        stat_words_q <= sat_inc16(stat_words_q);
      end
      // Only redirects that actually throw away a word are counted.
      if (redirect && (insn_valid || inflight_q)) begin
        stat_flushes_q <= sat_inc16(stat_flushes_q);
      end
    end
  end

  assign stat_words   = stat_words_q;
  assign stat_flushes = stat_flushes_q;
`else
  assign stat_words   = 16'h0000;
  assign stat_flushes = 16'h0000;
`endif

endmodule

// File: doc/insn_prefetch.md
# insn_prefetch

Instruction prefetch stage between the program ROM and the stack-machine core. Issues sequential ROM reads ahead of execution, buffers returned words with their addresses in a small FIFO, and presents them to the core over a valid/ready handshake. The core redirects fetch on JMP and can halt fetch on ERROR; redirect flushes all buffered and in-flight words.

## Interface
- DEPTH, 4, FIFO entries (power of two, ≥2)
- RESET_PC, 16'h0000, first fetch address after reset
- clock  in  1  system clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- address_rom  out  16  ROM read address (registered)
- q_rom  in  16  ROM data, valid the cycle after address_rom is driven
- insn_valid  out  1  head entry valid
- insn_word  out  16  head instruction/operand word
- insn_pc  out  16  ROM address of insn_word
- insn_ready  in  1  core accepts head this cycle
- redirect  in  1  flush and restart fetch
- redirect_pc  in  16  restart address
- halt  in  1  stop issuing new reads
- fetch_state  out  2  current FSM state (debug)
- stat_words  out  16  words written into FIFO
- stat_flushes  out  16  redirects that discarded data

## Operation
- ROM latency 1: address driven in cycle c → q_rom captured at end of c+1.
- fetch_pc register drives address_rom. Read "issued" in cycle c when state RUN and count + inflight < DEPTH; fetch_pc increments (16-bit wrap FFFF→0000).
- inflight flag and pc_q register track issued read; at end of c+1 word and pc_q written to FIFO unless killed.
- Pop when insn_valid && insn_ready. Simultaneous push/pop allowed; count unchanged.
- Credit check ignores same-cycle pop (conservative); no overflow possible.
- FSM: RUN (issuing), HOLD (credits exhausted; returns to RUN when credit frees), HALTED (entered when halt=1; sticky; leaves only via redirect → RUN or reset).
- Redirect in cycle c: at end of c FIFO cleared (pop in c discarded too), in-flight read killed, fetch_pc ← redirect_pc, state ← RUN. Overrides halt and HOLD. Consecutive redirects: last wins.
- Reset wins over redirect. Reset mid-stream: FIFO cleared, in-flight dropped, fetch_pc ← RESET_PC.
- Reset values: address_rom=RESET_PC, insn_valid=0, insn_word=0, insn_pc=0, fetch_state=RUN, stats=0.

## Timing
- After reset deasserts (cycle 0): address_rom=RESET_PC in cycle 0, data in cycle 1, insn_valid=1 in cycle 2.
- Redirect in cycle c: address_rom=redirect_pc in c+1, insn_valid with insn_pc=redirect_pc in c+3; insn_valid=0 in c+1 and c+2.
- Steady state with insn_ready=1: one word per cycle, no bubbles.
- insn_word/insn_pc held stable while insn_valid && !insn_ready.
- halt sampled in cycle c: no read issued in c or later; in-flight from c-1 still written.

## Configuration
- PREFETCH_STATS_EN defined: stat_words increments per FIFO write; stat_flushes increments per redirect when FIFO non-empty or inflight; both saturate at 16'hFFFF; cleared by reset.
- Not defined: counters not built, stat_words and stat_flushes tied to 16'h0000.

## Structure
- fetch_pkg: fetch state enum (RUN, HOLD, HALTED), ADDR_W=16, WORD_W=16.
- Sub-module prefetch_fifo: synchronous FIFO storing {pc, word}, with flush input, count output, registered head; top holds FSM, fetch_pc, inflight tracking, stats.

## Test plan
- ROM word = addr ^ 16'hA500, insn_ready=1 after reset → first valid cycle 2 with pc 0000/word A500, then pcs 0001, 0002, 0003 consecutive cycles.
- insn_ready=0 → exactly 4 entries, fetch_state=HOLD, address_rom stops at 0004; release ready → pcs 0000..0007 in order, none lost or duplicated.
- FIFO holding 3 words plus in-flight, redirect to 0100 → insn_valid low 2 cycles, then pc 0100 word A400; no stale word; stat_flushes=1.
- Redirect to FFFE → delivered pcs FFFE, FFFF, 0000, 0001.
- halt=1 with 2 queued → no further reads issued, queued plus in-flight drained, fetch_state=HALTED; redirect to 0020 → RUN, pc 0020 delivered 3 cycles later.
- reset asserted mid-stream with redirect=1 same cycle → next cycle insn_valid=0, address_rom=0000, stats 0; first valid pc 0000.
